// File: rtl/onehot_request_arbiter.sv
// onehot_request_arbiter
//   Captures rising edges on eight request lines into a pending vector and
//   hands them out one at a time as a registered one-hot grant under a
//   valid/ready handshake. The grant word always carries exactly one set bit
//   while o_grant_valid is high, so the downstream 8x3 encoder output is
//   meaningful whenever a grant is offered.
//
//   Configuration macro: ARB_FIXED_PRIO_EN
//     defined   -> fixed priority, lowest index wins, no round-robin pointer
//     undefined -> round-robin search starting at the pointer (default)
module onehot_request_arbiter #(
    parameter int NUM_REQ = 8,
    parameter int PTR_W   = 3
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [NUM_REQ-1:0] i_req_in,
    output logic [NUM_REQ-1:0] o_grant_onehot,
    output logic               o_grant_valid,
    input  logic               i_grant_ready,
    output logic [NUM_REQ-1:0] o_pending,
    output logic               o_overflow
);

    // The handshake state is exactly "a grant is being offered".
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_next;

    logic [NUM_REQ-1:0]   r_req_d;
    logic [NUM_REQ-1:0]   r_pending;
    logic [NUM_REQ-1:0]   r_grant_onehot;
    logic                 r_overflow;

    logic [NUM_REQ-1:0]   w_rise;
    logic                 w_sel_found;
    logic [PTR_W-1:0]     w_sel;
    logic                 w_load;
    logic                 w_accept;
    logic [NUM_REQ-1:0]   w_clr;
    logic [NUM_REQ-1:0]   w_pending_next;
    logic                 w_overflow_next;

`ifndef ARB_FIXED_PRIO_EN
    logic [PTR_W-1:0]     r_rr_ptr;
`endif

    // Rising-edge detection against the previous cycle's request levels.
    // After reset r_req_d is zero, so a line already high counts as one event.
    always_comb begin
        w_rise = i_req_in & ~r_req_d;
    end

`ifdef ARB_FIXED_PRIO_EN
    // Fixed priority: the lowest-index pending line wins.
    always_comb begin
        w_sel       = '0;
        w_sel_found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_sel_found && r_pending[k]) begin
                w_sel       = PTR_W'(k);
                w_sel_found = 1'b1;
            end
        end
    end
`else
    // Round-robin: search upward from the pointer, wrapping naturally through
    // the PTR_W-bit index arithmetic; the first pending line found wins.
    always_comb begin
        w_sel       = '0;
        w_sel_found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_sel_found && r_pending[r_rr_ptr + PTR_W'(k)]) begin
                w_sel       = r_rr_ptr + PTR_W'(k);
                w_sel_found = 1'b1;
            end
        end
    end
`endif

    // A new grant is loaded whenever something is pending and the output slot
    // is free or being freed this cycle; w_sel_found is equivalent to a
    // non-zero pending vector. The cleared bit is the one being granted.
    always_comb begin
        w_accept        = (r_state == ST_OFFER) && i_grant_ready;
        w_load          = w_sel_found && ((r_state == ST_IDLE) || i_grant_ready);
        w_clr           = w_load ? (NUM_REQ'(1) << w_sel) : '0;
        w_pending_next  = (r_pending & ~w_clr) | w_rise;
        w_overflow_next = |(w_rise & r_pending & ~w_clr);
    end

    // Handshake next-state: stay offering while back-to-back loads continue,
    // fall back to idle once an accepted grant leaves nothing pending.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_load) begin
                    w_state_next = ST_OFFER;
                end
            end
            ST_OFFER: begin
                if (w_accept && !w_load) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Handshake state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Request history, pending events and the overflow pulse.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_req_d    <= '0;
            r_pending  <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_req_d    <= i_req_in;
            r_pending  <= w_pending_next;
            r_overflow <= w_overflow_next;
        end
    end

    // Grant word: load a new one-hot grant, clear it on an accept with
    // nothing to follow, otherwise hold (this covers the stall case).
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_grant_onehot <= '0;
        end else if (w_load) begin
            r_grant_onehot <= NUM_REQ'(1) << w_sel;
        end else if (w_accept) begin
            r_grant_onehot <= '0;
        end
    end

`ifndef ARB_FIXED_PRIO_EN
    // Round-robin pointer moves just past the line that was granted.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rr_ptr <= '0;
        end else if (w_load) begin
            r_rr_ptr <= w_sel + PTR_W'(1);
        end
    end
`endif

    assign o_grant_onehot = r_grant_onehot;
    assign o_grant_valid  = (r_state == ST_OFFER);
    assign o_pending      = r_pending;
    assign o_overflow     = r_overflow;

endmodule

// File: tb/tb_onehot_request_arbiter.sv
// tb_onehot_request_arbiter
//   Scenario tasks for reset, single events, simultaneous events, stall,
//   overflow and fairness, followed by a randomized run against an
//   event-level reference model of the arbiter.
module tb_onehot_request_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] reqIn;
    logic       ready;
    logic [7:0] grantOnehot;
    logic       grantValid;
    logic [7:0] pendingOut;
    logic       overflowOut;

    int checkCount = 0;
    int passCount  = 0;

    // Reference model: set of outstanding events, current grant index
    // (-1 = none), search start index and previous request levels.
    bit mPend [8];
    bit mPrev [8];
    int mGrant;
    int mPtr;
    bit mOvf;

    onehot_request_arbiter dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_req_in       (reqIn),
        .o_grant_onehot (grantOnehot),
        .o_grant_valid  (grantValid),
        .i_grant_ready  (ready),
        .o_pending      (pendingOut),
        .o_overflow     (overflowOut)
    );

    always #5 clk = ~clk;

    function automatic void modelReset();
        for (int i = 0; i < 8; i++) begin
            mPend[i] = 1'b0;
            mPrev[i] = 1'b0;
        end
        mGrant = -1;
        mPtr   = 0;
        mOvf   = 1'b0;
    endfunction

    // One clock edge of the arbiter's event-level behaviour.
    function automatic void modelStep();
        bit anyPending;
        bit canLoad;
        int sel;
        int idx;
        bit rise [8];
        anyPending = 1'b0;
        for (int i = 0; i < 8; i++) if (mPend[i]) anyPending = 1'b1;
        canLoad = anyPending && (mGrant < 0 || ready);
        sel = -1;
        if (canLoad) begin
            for (int k = 0; k < 8; k++) begin
`ifdef ARB_FIXED_PRIO_EN
                idx = k;
`else
                idx = (mPtr + k) % 8;
`endif
                if (sel < 0 && mPend[idx]) sel = idx;
            end
        end
        mOvf = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rise[i] = reqIn[i] && !mPrev[i];
            if (rise[i] && mPend[i] && i != sel) mOvf = 1'b1;
        end
        if (canLoad) begin
            mPend[sel] = 1'b0;
            mGrant     = sel;
            mPtr       = (sel + 1) % 8;
        end else if (mGrant >= 0 && ready) begin
            mGrant = -1;
        end
        for (int i = 0; i < 8; i++) begin
            if (rise[i]) mPend[i] = 1'b1;
            mPrev[i] = reqIn[i];
        end
    endfunction

    function automatic logic [17:0] modelVector();
        logic [7:0] pv;
        logic [7:0] gv;
        pv = '0;
        for (int i = 0; i < 8; i++) pv[i] = mPend[i];
        gv = (mGrant < 0) ? 8'h00 : (8'h01 << mGrant);
        return {gv, (mGrant >= 0), pv, mOvf};
    endfunction

    // Advance one edge, step the model in step with the DUT, sample 1 ns later.
    task automatic tick();
        @(posedge clk);
        if (rst_n) modelStep();
        #1;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        reqIn = 8'h00;
        modelReset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        reqIn = 8'h00;
        ready = 1'b0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkCount++;
        if ({grantOnehot, grantValid, pendingOut, overflowOut} !== 18'h0)
            $display("[TB] FAIL reset_initial: got %h expected %h",
                     {grantOnehot, grantValid, pendingOut, overflowOut}, 18'h0);
        else passCount++;
        rst_n = 1'b1;
        reqIn = 8'h30;
        tick();
        tick();
        checkCount++;
        if ({grantValid, grantOnehot, pendingOut} !== {1'b1, 8'h10, 8'h20})
            $display("[TB] FAIL reset_pregrant: got v=%b g=%h p=%h expected v=1 g=10 p=20",
                     grantValid, grantOnehot, pendingOut);
        else passCount++;
        #2;
        rst_n = 1'b0;
        reqIn = 8'h00;
        modelReset();
        #1;
        checkCount++;
        if ({grantOnehot, grantValid, pendingOut, overflowOut} !== 18'h0)
            $display("[TB] FAIL reset_async: got %h expected %h",
                     {grantOnehot, grantValid, pendingOut, overflowOut}, 18'h0);
        else passCount++;
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            checkCount++;
            if ({grantValid, pendingOut} !== 9'h0)
                $display("[TB] FAIL reset_no_grant: cycle %0d got v=%b p=%h expected v=0 p=00",
                         c, grantValid, pendingOut);
            else passCount++;
        end
    endtask

    task automatic test_single();
        ready = 1'b1;
        reqIn = 8'h10;
        tick();
        checkCount++;
        if ({grantValid, pendingOut} !== {1'b0, 8'h10})
            $display("[TB] FAIL single_pending: got v=%b p=%h expected v=0 p=10", grantValid, pendingOut);
        else passCount++;
        tick();
        checkCount++;
        if ({grantValid, grantOnehot} !== {1'b1, 8'h10})
            $display("[TB] FAIL single_grant: got v=%b g=%h expected v=1 g=10", grantValid, grantOnehot);
        else passCount++;
        tick();
        checkCount++;
        if ({grantValid, grantOnehot} !== {1'b0, 8'h00})
            $display("[TB] FAIL single_drop: got v=%b g=%h expected v=0 g=00", grantValid, grantOnehot);
        else passCount++;
        reqIn = 8'h00;
        tick();
    endtask

    task automatic test_simultaneous();
        logic [7:0] firstExp;
        logic [7:0] secondExp;
        doReset();
        ready = 1'b1;
        reqIn = 8'h81;
        tick();
        tick();
        checkCount++;
        if (grantOnehot !== 8'h01 || grantValid !== 1'b1)
            $display("[TB] FAIL simul_first: got v=%b g=%h expected v=1 g=01", grantValid, grantOnehot);
        else passCount++;
        tick();
        checkCount++;
        if (grantOnehot !== 8'h80 || grantValid !== 1'b1)
            $display("[TB] FAIL simul_second: got v=%b g=%h expected v=1 g=80", grantValid, grantOnehot);
        else passCount++;
        tick();
        reqIn = 8'h00;
        tick();
        // Grant line 0 alone so the round-robin pointer sits at 1.
        reqIn = 8'h01;
        tick();
        tick();
        tick();
        reqIn = 8'h00;
        tick();
        reqIn = 8'h81;
`ifdef ARB_FIXED_PRIO_EN
        firstExp  = 8'h01;
        secondExp = 8'h80;
`else
        firstExp  = 8'h80;
        secondExp = 8'h01;
`endif
        tick();
        tick();
        checkCount++;
        if (grantOnehot !== firstExp)
            $display("[TB] FAIL simul_ptr1_first: got %h expected %h", grantOnehot, firstExp);
        else passCount++;
        tick();
        checkCount++;
        if (grantOnehot !== secondExp)
            $display("[TB] FAIL simul_ptr1_second: got %h expected %h", grantOnehot, secondExp);
        else passCount++;
        tick();
        reqIn = 8'h00;
        tick();
    endtask

    task automatic test_stall();
        doReset();
        ready = 1'b0;
        reqIn = 8'h06;
        tick();
        tick();
        for (int c = 0; c < 5; c++) begin
            tick();
            checkCount++;
            if ({grantValid, grantOnehot, pendingOut} !== {1'b1, 8'h02, 8'h04})
                $display("[TB] FAIL stall_hold: cycle %0d got v=%b g=%h p=%h expected v=1 g=02 p=04",
                         c, grantValid, grantOnehot, pendingOut);
            else passCount++;
        end
        ready = 1'b1;
        tick();
        checkCount++;
        if ({grantValid, grantOnehot, pendingOut} !== {1'b1, 8'h04, 8'h00})
            $display("[TB] FAIL stall_release: got v=%b g=%h p=%h expected v=1 g=04 p=00",
                     grantValid, grantOnehot, pendingOut);
        else passCount++;
        tick();
        checkCount++;
        if (grantValid !== 1'b0)
            $display("[TB] FAIL stall_idle: got v=%b expected v=0", grantValid);
        else passCount++;
        reqIn = 8'h00;
        tick();
    endtask

    task automatic test_overflow();
        int grants08;
        doReset();
        ready = 1'b0;
        reqIn = 8'h01;
        tick();
        tick();
        reqIn = 8'h09;
        tick();
        checkCount++;
        if ({overflowOut, pendingOut} !== {1'b0, 8'h08})
            $display("[TB] FAIL ovf_first_event: got o=%b p=%h expected o=0 p=08", overflowOut, pendingOut);
        else passCount++;
        reqIn = 8'h01;
        tick();
        reqIn = 8'h09;
        tick();
        checkCount++;
        if ({overflowOut, pendingOut} !== {1'b1, 8'h08})
            $display("[TB] FAIL ovf_pulse: got o=%b p=%h expected o=1 p=08", overflowOut, pendingOut);
        else passCount++;
        tick();
        checkCount++;
        if (overflowOut !== 1'b0)
            $display("[TB] FAIL ovf_one_cycle: got o=%b expected o=0", overflowOut);
        else passCount++;
        reqIn = 8'h00;
        ready = 1'b1;
        grants08 = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (grantValid === 1'b1 && grantOnehot === 8'h08) grants08++;
        end
        checkCount++;
        if (grants08 !== 1)
            $display("[TB] FAIL ovf_single_grant: got %0d grants of 08 expected 1", grants08);
        else passCount++;
    endtask

    task automatic test_fairness();
        int seq [$];
        int cnt [8];
        logic [17:0] expVec;
        doReset();
        ready = 1'b1;
        for (int i = 0; i < 8; i++) cnt[i] = 0;
        for (int c = 0; c < 48; c++) begin
            reqIn = (((c / 3) % 2) == 0) ? 8'hFF : 8'h00;
            tick();
            expVec = modelVector();
            checkCount++;
            if ({grantOnehot, grantValid, pendingOut, overflowOut} !== expVec)
                $display("[TB] FAIL fair_model: cycle %0d got %h expected %h",
                         c, {grantOnehot, grantValid, pendingOut, overflowOut}, expVec);
            else passCount++;
            if (grantValid === 1'b1) begin
                for (int i = 0; i < 8; i++) begin
                    if (grantOnehot === (8'h01 << i)) begin
                        seq.push_back(i);
                        cnt[i]++;
                    end
                end
            end
        end
`ifdef ARB_FIXED_PRIO_EN
        checkCount++;
        if (cnt[0] <= cnt[7])
            $display("[TB] FAIL fair_fixed_dominance: got bit0=%0d bit7=%0d expected bit0 > bit7", cnt[0], cnt[7]);
        else passCount++;
`else
        checkCount++;
        if (seq.size() < 40)
            $display("[TB] FAIL fair_count: got %0d grants expected at least 40", seq.size());
        else passCount++;
        for (int i = 0; i < seq.size(); i++) begin
            checkCount++;
            if (seq[i] != (i % 8))
                $display("[TB] FAIL fair_order: grant %0d got line %0d expected line %0d", i, seq[i], i % 8);
            else passCount++;
        end
`endif
        reqIn = 8'h00;
        repeat (10) tick();
    endtask

    task automatic test_random();
        logic [17:0] expVec;
        doReset();
        for (int c = 0; c < 400; c++) begin
            reqIn = 8'($urandom) & 8'($urandom);
            ready = ($urandom_range(0, 3) != 0);
            tick();
            expVec = modelVector();
            checkCount++;
            if ({grantOnehot, grantValid, pendingOut, overflowOut} !== expVec)
                $display("[TB] FAIL rand_model: cycle %0d got %h expected %h",
                         c, {grantOnehot, grantValid, pendingOut, overflowOut}, expVec);
            else passCount++;
            if ($urandom_range(0, 99) == 0) begin
                rst_n = 1'b0;
                modelReset();
                #1;
                checkCount++;
                if ({grantOnehot, grantValid, pendingOut, overflowOut} !== 18'h0)
                    $display("[TB] FAIL rand_reset: cycle %0d got %h expected 0",
                             c, {grantOnehot, grantValid, pendingOut, overflowOut});
                else passCount++;
                tick();
                rst_n = 1'b1;
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_stall();
        test_overflow();
        test_fairness();
        test_random();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
